// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: producer/consumer handshake, head entry and status signals of the ALU result stage
interface alu_result_stage_if;
  logic        input_Valid;
  logic [15:0] input_ALUResult;
  logic        input_Zero;
  logic        input_negative;
  logic [1:0]  input_BranchCond;
  logic        input_FlagWrite;
  logic        input_Ready;
  logic        output_Ready;
  logic        output_Valid;
  logic [15:0] output_Result;
  logic        output_Zero;
  logic        output_Negative;
  logic        output_BranchTaken;
  logic        output_FlagZ;
  logic        output_FlagN;
  logic [1:0]  output_Count;
  logic        output_Overflow;
  modport slave (
    input  input_Valid, input_ALUResult, input_Zero, input_negative, input_BranchCond, input_FlagWrite, input_Ready,
    output output_Ready, output_Valid, output_Result, output_Zero, output_Negative, output_BranchTaken,
    output output_FlagZ, output_FlagN, output_Count, output_Overflow
  );
  modport master (
    output input_Valid, input_ALUResult, input_Zero, input_negative, input_BranchCond, input_FlagWrite, input_Ready,
    input  output_Ready, output_Valid, output_Result, output_Zero, output_Negative, output_BranchTaken,
    input  output_FlagZ, output_FlagN, output_Count, output_Overflow
  );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry FIFO of {result, zero, negative, branch taken} with condition flags and sticky overflow
module alu_result_stage (
  input logic input_CLK,
  input logic input_Reset,
  alu_result_stage_if.slave bus
);
  logic [1:0]  count;
  logic        wp, rp, flag_z, flag_n, ovf;
  logic [18:0] mem [2];
  logic        full, has, push, pop, taken;
  logic [18:0] head;
  assign full = count[1];
  assign has  = |count;
  assign push = bus.input_Valid & ~full;
  assign pop  = has & bus.input_Ready;
  always_comb begin
    taken = bus.input_BranchCond == 2'b00 ? 1'b0 :
            bus.input_BranchCond == 2'b01 ? bus.input_Zero :
            bus.input_BranchCond == 2'b10 ? ~bus.input_Zero : bus.input_negative;
    head  = has ? mem[rp] : '0;
  end
  // storage needs no reset: the head is masked to zero whenever the buffer is empty
  always_ff @(posedge input_CLK) begin
    if (push) mem[wp] <= {bus.input_ALUResult, bus.input_Zero, bus.input_negative, taken};
  end
  always_ff @(posedge input_CLK) begin
    if (input_Reset) begin
      count  <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      if (push & bus.input_FlagWrite) begin
        flag_z <= bus.input_Zero;
        flag_n <= bus.input_negative;
      end
      if (bus.input_Valid & full) ovf <= 1'b1;
    end
  end
  assign bus.output_Ready       = ~full;
  assign bus.output_Valid       = has;
  assign bus.output_Result      = head[18:3];
  assign bus.output_Zero        = head[2];
  assign bus.output_Negative    = head[1];
  assign bus.output_BranchTaken = head[0];
  assign bus.output_FlagZ       = flag_z;
  assign bus.output_FlagN       = flag_n;
  assign bus.output_Count       = count;
  assign bus.output_Overflow    = ovf;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random traffic against a queue model, checked by a decoupled negedge monitor
module tb_alu_result_stage;
  logic input_CLK = 1'b0;
  logic input_Reset;
  alu_result_stage_if bus();
  alu_result_stage dut (.input_CLK(input_CLK), .input_Reset(input_Reset), .bus(bus));
  always #5 input_CLK = ~input_CLK;
  int n_cmp = 0, n_bad = 0;
  logic [18:0] sb [$];
  int occ = 0;
  logic m_fz = 1'b0, m_fn = 1'b0, m_ovf = 1'b0, live = 1'b0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic branch(input logic [1:0] c, input logic z, input logic n);
    case (c)
      2'd0: return 1'b0;
      2'd1: return z;
      2'd2: return !z;
      default: return n;
    endcase
  endfunction
  // one clock: drive inputs, let the edge pass, then advance the model
  task automatic cyc(input logic v, input logic [15:0] d, input logic z, input logic n,
                     input logic [1:0] c, input logic fw, input logic rdy, input logic r);
    bit acc;
    bit pp;
    bus.input_Valid = v; bus.input_ALUResult = d; bus.input_Zero = z; bus.input_negative = n;
    bus.input_BranchCond = c; bus.input_FlagWrite = fw; bus.input_Ready = rdy; input_Reset = r;
    @(posedge input_CLK);
    #1;
    if (r) begin
      sb.delete(); occ = 0; m_fz = 1'b0; m_fn = 1'b0; m_ovf = 1'b0;
    end else begin
      pp  = occ > 0 && rdy;
      acc = v && occ < 2;
      if (v && occ == 2) m_ovf = 1'b1;
      if (acc) begin
        sb.push_back({d, z, n, branch(c, z, n)});
        if (fw) begin m_fz = z; m_fn = n; end
      end
      occ = occ + int'(acc) - int'(pp);
    end
    live = 1'b1;
  endtask
  always @(negedge input_CLK) begin
    if (live) begin
      chk("count", int'(bus.output_Count), occ);
      chk("ready", int'(bus.output_Ready), int'(occ < 2));
      chk("valid", int'(bus.output_Valid), int'(occ != 0));
      chk("flag_z", int'(bus.output_FlagZ), int'(m_fz));
      chk("flag_n", int'(bus.output_FlagN), int'(m_fn));
      chk("overflow", int'(bus.output_Overflow), int'(m_ovf));
      if (bus.output_Valid) begin
        if (sb.size() == 0) chk("head_unexpected", 1, 0);
        else begin
          chk("head", int'({bus.output_Result, bus.output_Zero, bus.output_Negative, bus.output_BranchTaken}), int'(sb[0]));
          if (bus.input_Ready) void'(sb.pop_front());
        end
      end else
        chk("empty_head", int'({bus.output_Result, bus.output_Zero, bus.output_Negative, bus.output_BranchTaken}), 0);
    end
  end
  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 16'h1234, 0, 0, 2'b10, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 16'h0000, 1, 0, 2'b01, 0, 0, 0);
    cyc(1, 16'h8000, 0, 1, 2'b11, 0, 0, 0);
    cyc(1, 16'hFFFF, 1, 1, 2'b00, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 16'h0001, 1, 0, 2'b01, 1, 0, 0);
    cyc(1, 16'h0002, 0, 0, 2'b10, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 16'h0100, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 16'h0200 + 16'(i), i[0], i[1], 2'(i), 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 16'hA5A5, 0, 1, 2'b11, 1, 0, 0);
    cyc(1, 16'h5A5A, 1, 0, 2'b01, 1, 0, 0);
    cyc(1, 16'hFFFF, 0, 0, 2'b10, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
          1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 150) == 0));
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge input_CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have no parameters; data width fixed at 16 bits and buffer depth fixed at 2 entries.
REQ-002 SHALL provide input_CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide input_Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL provide input_Valid  in  1  ALU result offered this cycle.
REQ-005 SHALL provide input_ALUResult  in  16  ALU output word.
REQ-006 SHALL provide input_Zero  in  1  ALU zero flag.
REQ-007 SHALL provide input_negative  in  1  ALU negative flag.
REQ-008 SHALL provide input_BranchCond  in  2  00 none, 01 BEQ (zero), 10 BNE (not zero), 11 BLT (negative).
REQ-009 SHALL provide input_FlagWrite  in  1  update condition flags on accept.
REQ-010 SHALL provide output_Ready  out  1  stage can accept (not full).
REQ-011 SHALL provide output_Valid  out  1  head entry present.
REQ-012 SHALL provide output_Result  out  16  head entry result.
REQ-013 SHALL provide output_Zero, output_Negative  out  1 each  head entry flags.
REQ-014 SHALL provide output_BranchTaken  out  1  head entry branch decision.
REQ-015 SHALL provide input_Ready  in  1  downstream consumes head this cycle.
REQ-016 SHALL provide output_FlagZ, output_FlagN  out  1 each  architectural condition flags.
REQ-017 SHALL provide output_Count  out  2  entries held (0..2).
REQ-018 SHALL provide output_Overflow  out  1  sticky: offer dropped while full.

Function
REQ-019 Push SHALL occur when input_Valid=1 and output_Ready=1; pop SHALL occur when output_Valid=1 and input_Ready=1.
REQ-020 output_Ready SHALL be 1 iff Count<2, derived from registered state only (no combinational path from input_Ready).
REQ-021 Entry SHALL store {result, zero, negative, taken}, taken computed at push: 00->0, 01->zero, 10->~zero, 11->negative.
REQ-022 Pushed entry SHALL appear at outputs the cycle after push when buffer was empty (latency 1); otherwise after all older entries pop (FIFO order).
REQ-023 output_Valid SHALL equal (Count!=0); when empty, output_Result, output_Zero, output_Negative, output_BranchTaken SHALL be 0.
REQ-024 Simultaneous push and pop SHALL leave Count unchanged; pop SHALL apply to the old head, push to the tail; legal at Count 1 and, for pop only, at Count 2.
REQ-025 At Count=2 with input_Valid=1, offer SHALL be dropped even if input_Ready=1 the same cycle, and output_Overflow SHALL set and hold until reset.
REQ-026 Pop at Count=0 SHALL have no effect (input_Ready ignored when empty).
REQ-027 Read/write pointers SHALL be 1 bit each and wrap 1->0.
REQ-028 On push with input_FlagWrite=1, output_FlagZ/output_FlagN SHALL take input_Zero/input_negative the next cycle; otherwise hold; dropped offers SHALL NOT update flags.
REQ-029 Head outputs SHALL be stable while output_Valid=1 and input_Ready=0.

Reset
REQ-030 While input_Reset=1 at a clock edge: Count=0, pointers=0, output_Valid=0, output_Ready=1 next cycle, output_FlagZ=0, output_FlagN=0, output_Overflow=0, head outputs 0.
REQ-031 Reset SHALL take priority over simultaneous push/pop; buffered entries SHALL be discarded mid-operation.

Verification
REQ-032 Single push: Result=16'h1234, Zero=0, Cond=10, input_Ready=0 -> next cycle Valid=1, Result=16'h1234, BranchTaken=1, Count=1.
REQ-033 Fill: push 16'h0000 (Zero=1, Cond=01) then 16'h8000 (Neg=1, Cond=11), input_Ready=0 -> Count=2, Ready=0; then input_Ready=1 two cycles -> heads 16'h0000/Taken=1 then 16'h8000/Taken=1, Count 0.
REQ-034 Overflow: Count=2, input_Valid=1 with 16'hFFFF and FlagWrite=1 -> dropped, Overflow=1 sticky, FlagZ/FlagN unchanged, Count=2.
REQ-035 Simultaneous push/pop at Count=1 over 8 cycles with incrementing data -> Count stays 1, outputs delayed by exactly 1 cycle, order preserved.
REQ-036 Flags: push Zero=1, FlagWrite=1 -> FlagZ=1; push Zero=0, FlagWrite=0 -> FlagZ stays 1.
REQ-037 Reset at Count=2 with Overflow=1 -> next cycle Count=0, Valid=0, Ready=1, Overflow=0, FlagZ=FlagN=0.
